// File: rtl/max7219_rx.sv
// Responder end of the MAX7219 3-wire serial interface: oversamples DIN/nCS/CLK,
// assembles 16-bit frames, decodes them into the register file and drives DOUT.
module max7219_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk_System,
  input  logic       Rst_System,
  input  logic       max7219_din,
  input  logic       max7219_ncs,
  input  logic       max7219_clk,
  output logic       max7219_dout,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  input  logic [2:0] digit_sel,
  output logic [7:0] digit_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown_n,
  output logic       display_test
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  localparam logic [4:0] L_FULL = 5'd16;
  localparam logic [4:0] L_SAT  = 5'd31;

  logic [SYNC_STAGES-1:0] r_din_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic                   r_clk_d;
  logic                   r_ncs_d;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_clear;
  logic                   w_shift;
  logic                   w_dout_ld;
  logic                   w_latch;

  logic [FRAME_BITS-1:0]  r_shreg;
  logic [4:0]             r_count;
  logic                   r_dout;
  logic                   r_frame_valid;
  logic                   r_frame_err;
  logic [3:0]             r_frame_addr;
  logic [7:0]             r_frame_data;
  logic [7:0]             r_digit [8];
  logic [7:0]             r_decode_mode;
  logic [3:0]             r_intensity;
  logic [2:0]             r_scan_limit;
  logic                   r_shutdown_n;
  logic                   r_display_test;

  logic                   w_din_s;
  logic                   w_ncs_s;
  logic                   w_clk_s;
  logic                   w_clk_rise;
  logic                   w_clk_fall;
  logic                   w_ncs_rise;
  logic                   w_ncs_fall;
  logic                   w_full;
  logic [3:0]             w_addr;
  logic [7:0]             w_data;
  logic [2:0]             w_digit_idx;

  assign w_din_s     = r_din_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
  assign w_clk_rise  = w_clk_s & ~r_clk_d;
  assign w_clk_fall  = ~w_clk_s & r_clk_d;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
  assign w_full      = (r_count >= L_FULL);
  assign w_addr      = r_shreg[11:8];
  assign w_data      = r_shreg[7:0];
  assign w_digit_idx = 3'(w_addr - 4'd1);

  // Synchronizer chains and edge-detect history
  always_ff @(posedge Clk_System or posedge Rst_System) begin
    if (Rst_System) begin
      r_din_sync <= {SYNC_STAGES{1'b0}};
      r_ncs_sync <= {SYNC_STAGES{1'b0}};
      r_clk_sync <= {SYNC_STAGES{1'b0}};
      r_clk_d    <= 1'b0;
      r_ncs_d    <= 1'b0;
    end else begin
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], max7219_din};
      r_ncs_sync <= {r_ncs_sync[SYNC_STAGES-2:0], max7219_ncs};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], max7219_clk};
      r_clk_d    <= w_clk_s;
      // Frozen during LATCH so an nCS fall in that cycle is still seen in IDLE
      r_ncs_d    <= (r_state == S_LATCH) ? r_ncs_d : w_ncs_s;
    end
  end

  // FSM state register
  always_ff @(posedge Clk_System or posedge Rst_System) begin
    if (Rst_System) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_dout_ld    = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ncs_fall) begin
          w_state_next = S_SHIFT;
          w_clear      = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_shift   = w_clk_rise & ~w_ncs_s;
        w_dout_ld = w_clk_fall & ~w_ncs_s;
        if (w_ncs_rise) begin
          w_state_next = S_LATCH;
        end else begin
          w_state_next = S_SHIFT;
        end
      end
      S_LATCH: begin
        w_latch      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Shift register, saturating bit counter and daisy-chain output
  always_ff @(posedge Clk_System or posedge Rst_System) begin
    if (Rst_System) begin
      r_shreg <= {FRAME_BITS{1'b0}};
      r_count <= 5'd0;
      r_dout  <= 1'b0;
    end else begin
      if (w_clear) begin
        r_shreg <= {FRAME_BITS{1'b0}};
        r_count <= 5'd0;
      end else if (w_shift) begin
        r_shreg <= {r_shreg[FRAME_BITS-2:0], w_din_s};
        if (r_count != L_SAT) begin
          r_count <= r_count + 5'd1;
        end
      end
      if (w_dout_ld) begin
        r_dout <= r_shreg[FRAME_BITS-1];
      end
    end
  end

  // Frame latch, status pulses and register file decode
  always_ff @(posedge Clk_System or posedge Rst_System) begin
    if (Rst_System) begin
      r_frame_valid  <= 1'b0;
      r_frame_err    <= 1'b0;
      r_frame_addr   <= 4'd0;
      r_frame_data   <= 8'd0;
      r_decode_mode  <= 8'd0;
      r_intensity    <= 4'd0;
      r_scan_limit   <= 3'd0;
      r_shutdown_n   <= 1'b0;
      r_display_test <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_digit[i] <= 8'd0;
      end
    end else begin
      r_frame_valid <= w_latch & w_full;
      r_frame_err   <= w_latch & ~w_full;
      if (w_latch & w_full) begin
        r_frame_addr <= w_addr;
        r_frame_data <= w_data;
        case (w_addr)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: r_digit[w_digit_idx] <= w_data;
          4'h9:    r_decode_mode  <= w_data;
          4'hA:    r_intensity    <= w_data[3:0];
          4'hB:    r_scan_limit   <= w_data[2:0];
          4'hC:    r_shutdown_n   <= w_data[0];
          4'hF:    r_display_test <= w_data[0];
          default: ;
        endcase
      end
    end
  end

  assign max7219_dout = r_dout;
  assign frame_valid  = r_frame_valid;
  assign frame_err    = r_frame_err;
  assign frame_addr   = r_frame_addr;
  assign frame_data   = r_frame_data;
  assign digit_data   = r_digit[digit_sel];
  assign decode_mode  = r_decode_mode;
  assign intensity    = r_intensity;
  assign scan_limit   = r_scan_limit;
  assign shutdown_n   = r_shutdown_n;
  assign display_test = r_display_test;

endmodule
